// File: rtl/dc_fifo_pkg.sv
// Shared helpers for the dual-clock token-ring FIFO halves.
package dc_fifo_pkg;

  // Widest token/pointer the rotate helper supports.
  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned IDX_W     = $clog2(MAX_DEPTH);

  // Value of every one-hot token/pointer flop while in reset (slot 0).
  localparam int unsigned RST_TOKEN = 1;

  // Rotate the low 'width' bits of a one-hot vector left by one; bit width-1 wraps to bit 0.
  function automatic logic [MAX_DEPTH-1:0] rotl_onehot(input logic [MAX_DEPTH-1:0] vec,
                                                       input int unsigned          width);
    logic [MAX_DEPTH-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < MAX_DEPTH; i++) begin
      if (i < width) r[IDX_W'(i)] = vec[IDX_W'(i - 1)];
    end
    r[0] = vec[IDX_W'(width - 1)];
    return r;
  endfunction

endpackage

// File: rtl/dc_onehot_sync.sv
// Two-flop synchronizer for a one-hot pointer plus one history stage.
module dc_onehot_sync
  import dc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = RST_TOKEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] rp_sync,
  output logic [WIDTH-1:0] rp_hist
);

  logic [WIDTH-1:0] stage1;

  // Per-bit 2-FF synchronizer followed by a history flop holding the previous synced value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage1  <= WIDTH'(RST_VAL);
      rp_sync <= WIDTH'(RST_VAL);
      rp_hist <= WIDTH'(RST_VAL);
    end else begin
      stage1  <= ptr;
      rp_sync <= stage1;
      rp_hist <= rp_sync;
    end
  end

endmodule

// File: rtl/dc_token_ring_wr_port.sv
// Source-domain write half of the dual-clock token-ring FIFO.
// Usable capacity is BUFFER_DEPTH-1; BUFFER_DEPTH must be in [3, MAX_DEPTH].
module dc_token_ring_wr_port
  import dc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [BUFFER_DEPTH-1:0] write_token_o,
  input  logic [BUFFER_DEPTH-1:0] read_pointer_i,
  output logic [DATA_WIDTH-1:0]   data_async_o
);

  logic [BUFFER_DEPTH-1:0] token;
  logic [BUFFER_DEPTH-1:0] token_next;
  logic [DATA_WIDTH-1:0]   buffer [BUFFER_DEPTH];
  logic [BUFFER_DEPTH-1:0] rp_sync;
  logic [BUFFER_DEPTH-1:0] rp_hist;
  logic                    full;
  logic                    push;
  logic [DATA_WIDTH-1:0]   data_mux;

  dc_onehot_sync #(
    .WIDTH   (BUFFER_DEPTH),
    .RST_VAL (RST_TOKEN)
  ) u_rp_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .ptr     (read_pointer_i),
    .rp_sync (rp_sync),
    .rp_hist (rp_hist)
  );

  assign token_next = BUFFER_DEPTH'(rotl_onehot(MAX_DEPTH'(token), BUFFER_DEPTH));

  // Full when the slot after the write token is (or recently was) the reader's slot;
  // OR-ing two sync samples keeps transitional pointer values from hiding a full buffer.
  assign full    = |(token_next & (rp_sync | rp_hist));
  assign ready_o = ~full & ~rst_i;
  assign push    = valid_i & ready_o;

  // Token crosses the clock boundary, so it is driven straight from its flop.
  assign write_token_o = token;

  // Store the beat in the slot the token selects and advance the token on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      token <= BUFFER_DEPTH'(RST_TOKEN);
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) buffer[i] <= '0;
    end else if (push) begin
      token <= token_next;
      for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
        if (token[i]) buffer[i] <= data_i;
      end
    end
  end

  // AND-OR read mux selected directly by the reader's one-hot pointer.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
      data_mux = data_mux | (buffer[i] & {DATA_WIDTH{read_pointer_i[i]}});
    end
  end

  assign data_async_o = data_mux;

endmodule

// File: tb/tb_dc_token_ring_wr_port.sv
// Self-checking bench for dc_token_ring_wr_port (DATA_WIDTH=32, BUFFER_DEPTH=8).
module tb_dc_token_ring_wr_port;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [7:0]  wtok;
  logic [7:0]  rp;
  logic [31:0] dout;

  int n_cmp;
  int n_err;

  // Bench model: slot contents, token index, pointer synchronizer pipeline.
  logic [31:0] m_buf [8];
  int          m_tok;
  logic [7:0]  m_s1, m_s2, m_hist;

  typedef struct {
    int          slot;
    logic [31:0] val;
  } wr_t;
  wr_t sb[$];

  dc_token_ring_wr_port #(
    .DATA_WIDTH   (32),
    .BUFFER_DEPTH (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_i         (data),
    .valid_i        (valid),
    .ready_o        (ready),
    .write_token_o  (wtok),
    .read_pointer_i (rp),
    .data_async_o   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] onehot(input int idx);
    logic [7:0] v;
    v = 8'h00;
    v[3'(idx)] = 1'b1;
    return v;
  endfunction

  // Ready as the model predicts it: not in reset and the slot after the token not seen by the reader.
  function automatic logic model_ready();
    logic [7:0] seen;
    seen = m_s2 | m_hist;
    return !rst && !seen[3'((m_tok + 1) % 8)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_buf[i] = 32'h0;
    m_tok  = 0;
    m_s1   = 8'h01;
    m_s2   = 8'h01;
    m_hist = 8'h01;
    sb.delete();
  endtask

  // Advance one clock (called at a negedge), updating the model on the posedge.
  task automatic step();
    logic hs;
    hs = valid && model_ready();
    @(posedge clk);
    if (hs) begin
      m_buf[m_tok] = data;
      sb.push_back('{slot: m_tok, val: data});
      m_tok = (m_tok + 1) % 8;
    end
    m_hist = m_s2;
    m_s2   = m_s1;
    m_s1   = rp;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    valid = 1'b0;
    rp    = 8'h01;
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b0;
    data  = 32'h0;
    rp    = 8'h01;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wtok !== 8'h01) begin n_err++; $display("FAIL reset_token got=%h exp=%h", wtok, 8'h01); end
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", dout); end
    #2 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
  endtask

  task automatic test_fill();
    wr_t e;
    for (int k = 0; k < 7; k++) begin
      valid = 1'b1;
      data  = 32'hA0 + 32'(k);
      n_cmp++;
      if (ready !== model_ready()) begin n_err++; $display("FAIL fill_ready beat=%0d got=%b exp=%b", k, ready, model_ready()); end
      step();
    end
    valid = 1'b0;
    n_cmp++;
    if (wtok !== 8'h80) begin n_err++; $display("FAIL fill_token got=%h exp=80", wtok); end
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got=%b exp=0", ready); end
    // Attempt a write while full.
    valid = 1'b1;
    data  = 32'hFF;
    step();
    valid = 1'b0;
    n_cmp++;
    if (wtok !== 8'h80) begin n_err++; $display("FAIL fill_blocked_token got=%h exp=80", wtok); end
    rp = 8'h80;
    #1;
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL fill_slot7_empty got=%h exp=0", dout); end
    rp = 8'h01;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step();
      rp = onehot(e.slot);
      #1;
      n_cmp++;
      if (dout !== e.val) begin n_err++; $display("FAIL fill_slot%0d got=%h exp=%h", e.slot, dout, e.val); end
      rp = 8'h01;
    end
  endtask

  task automatic test_release();
    wr_t e;
    rp = 8'h02;
    step();
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL release_edge1 got=%b exp=0", ready); end
    step();
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL release_edge2 got=%b exp=0", ready); end
    step();
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL release_edge3 got=%b exp=1", ready); end
    valid = 1'b1;
    data  = 32'hB7;
    step();
    valid = 1'b0;
    n_cmp++;
    if (wtok !== 8'h01) begin n_err++; $display("FAIL release_token got=%h exp=01", wtok); end
    e = sb.pop_front();
    rp = onehot(e.slot);
    #1;
    n_cmp++;
    if (dout !== e.val) begin n_err++; $display("FAIL release_slot%0d got=%h exp=%h", e.slot, dout, e.val); end
    rp = 8'h02;
  endtask

  task automatic test_wrap();
    int          accepted;
    int          cyc;
    logic        hs;
    logic [31:0] last [8];
    logic        touched [8];
    wr_t         e;
    accepted = 0;
    cyc      = 0;
    while (accepted < 20 && cyc < 300) begin
      valid = 1'b1;
      data  = 32'h100 + 32'(accepted);
      hs    = model_ready();
      n_cmp++;
      if (ready !== hs) begin n_err++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cyc, ready, hs); end
      step();
      if (hs) accepted++;
      n_cmp++;
      if (wtok !== onehot(m_tok)) begin n_err++; $display("FAIL wrap_token cyc=%0d got=%h exp=%h", cyc, wtok, onehot(m_tok)); end
      cyc++;
      if (cyc % 2 == 0) rp = {rp[6:0], rp[7]};
    end
    valid = 1'b0;
    n_cmp++;
    if (accepted != 20) begin n_err++; $display("FAIL wrap_timeout accepted=%0d exp=20", accepted); end
    for (int i = 0; i < 8; i++) touched[i] = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      last[e.slot]    = e.val;
      touched[e.slot] = 1'b1;
    end
    for (int s = 0; s < 8; s++) begin
      if (touched[s]) begin
        logic [7:0] save;
        save = rp;
        rp   = onehot(s);
        #1;
        n_cmp++;
        if (dout !== last[s]) begin n_err++; $display("FAIL wrap_slot%0d got=%h exp=%h", s, dout, last[s]); end
        rp = save;
        step();
      end
    end
  endtask

  task automatic test_output_mux();
    wr_t e;
    apply_reset();
    valid = 1'b1;
    data  = 32'h11;
    step();
    data  = 32'h22;
    step();
    valid = 1'b0;
    e  = sb.pop_front();
    rp = onehot(e.slot);
    #1;
    n_cmp++;
    if (dout !== e.val) begin n_err++; $display("FAIL mux_first got=%h exp=%h", dout, e.val); end
    e  = sb.pop_front();
    rp = onehot(e.slot);
    #1;
    n_cmp++;
    if (dout !== e.val) begin n_err++; $display("FAIL mux_second got=%h exp=%h", dout, e.val); end
    rp = 8'h01;
  endtask

  task automatic test_reset_mid_op();
    wr_t e;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1;
      data  = 32'h50 + 32'(k);
      step();
    end
    valid = 1'b0;
    n_cmp++;
    if (wtok !== 8'h20) begin n_err++; $display("FAIL midrst_pre_token got=%h exp=20", wtok); end
    e = sb.pop_front();
    n_cmp++;
    if (dout !== e.val) begin n_err++; $display("FAIL midrst_pre_slot0 got=%h exp=%h", dout, e.val); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (wtok !== 8'h01) begin n_err++; $display("FAIL midrst_token got=%h exp=01", wtok); end
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    n_cmp++;
    if (dout !== 32'h0) begin n_err++; $display("FAIL midrst_data got=%h exp=0", dout); end
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_resume_ready got=%b exp=1", ready); end
    valid = 1'b1;
    data  = 32'h77;
    step();
    valid = 1'b0;
    n_cmp++;
    if (wtok !== 8'h02) begin n_err++; $display("FAIL midrst_resume_token got=%h exp=02", wtok); end
    e = sb.pop_front();
    n_cmp++;
    if (dout !== e.val) begin n_err++; $display("FAIL midrst_resume_data got=%h exp=%h", dout, e.val); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_release();
    test_wrap();
    test_output_mux();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
